aes_round_sched: RTL and testbench
==================================

// Module: aes_round_sched
// PURPOSE
//   Sequencer for one AES-128 encryption. Accepts a block request on a valid/ready handshake,
//   then drives the key-expansion unit (load / step) and the round datapath (initial AddRoundKey,
//   rounds 1..NUM_ROUNDS, MixColumns skipped on the final round). Offers the result on a
//   valid/ready output handshake. Control only: no key or state bits pass through this block.
// PARAMETERS
//   NUM_ROUNDS  10  number of cipher rounds; must be in 2..(2**RIDX_W - 1)
//   RIDX_W      4   width of round_idx
// PORTS
//   CLK          in   1       clock, all state updates on posedge
//   RST          in   1       asynchronous, active-high reset
//   flush        in   1       synchronous abort; returns the block to IDLE
//   in_valid     in   1       request for a new block; plaintext is presented to the datapath
//   in_ready     out  1       block can accept a request (high only in IDLE)
//   out_valid    out  1       ciphertext in the datapath is final
//   out_ready    in   1       consumer accepts the ciphertext
//   ks_load      out  1       to key expansion: reload cipher key and reset its round counter
//   ks_step      out  1       to key expansion: advance to the next round key
//   dp_load      out  1       datapath: capture plaintext
//   dp_add0      out  1       datapath: state ^= round key 0
//   dp_round_en  out  1       datapath: perform one full round with the current round key
//   dp_skip_mix  out  1       datapath: bypass MixColumns (asserted only with dp_round_en)
//   round_idx    out  RIDX_W  round currently executing (0 = initial AddRoundKey)
//   busy         out  1       high in every state except IDLE
// BEHAVIOUR
//   Reset (RST high, asynchronous): state=IDLE, round counter=0. While reset is asserted and on
//     exit from reset, every output is 0 except in_ready. in_ready=1 because it decodes IDLE.
//   All outputs are combinational decodes of the registered state and the round counter.
//   FSM states: IDLE, LOAD, ADD0, ROUND, DONE.
//     IDLE : in_ready=1. Transition to LOAD when in_valid && !flush; this edge is the accept edge.
//     LOAD : one cycle. ks_load=1, dp_load=1, round_idx=0. Next state is ADD0.
//            Round key 0 becomes valid at the end of this cycle.
//     ADD0 : one cycle. dp_add0=1, ks_step=1, round_idx=0. Next state is ROUND with counter=1.
//     ROUND: dp_round_en=1, round_idx=counter.
//            ks_step=1 while counter<NUM_ROUNDS, so the next key is ready for the next round.
//            On counter==NUM_ROUNDS: ks_step=0, dp_skip_mix=1, next state is DONE.
//            Otherwise the counter increments by 1.
//     DONE : out_valid=1, round_idx=NUM_ROUNDS.
//            Holds indefinitely, outputs stable, while out_ready=0.
//            Transition to IDLE on out_ready=1.
//   Latency: accept edge E. LOAD is cycle E+1, ADD0 is E+2, rounds 1..NUM_ROUNDS are
//     E+3..E+NUM_ROUNDS+2. out_valid first goes high in cycle E+NUM_ROUNDS+3 (13 for the defaults).
//   Throughput: one block per NUM_ROUNDS+4 cycles minimum. in_ready stays low from LOAD through
//     DONE; there is no overlap. A request and an output handshake in the same cycle are not
//     possible by construction.
//   ks_load and ks_step are never high in the same cycle.
//   ks_step pulses exactly NUM_ROUNDS times per block.
//   dp_round_en pulses exactly NUM_ROUNDS times per block, with dp_skip_mix only on the last.
//   flush: in any state, the next state is IDLE with counter=0, and no datapath or key strobe is
//     asserted in the cycle after flush. flush overrides in_valid in IDLE (no accept) and
//     out_ready in DONE (no separate completion). After a flush, the key unit is reloaded by the
//     next LOAD.
//   Reset mid-operation: immediately IDLE, all strobes 0. The partial block is discarded.
//   The round counter saturates, never wraps. A counter value above NUM_ROUNDS is unreachable.
//     If it ever occurs, the FSM forces DONE->IDLE semantics: next state is IDLE.
// TESTING
//   1 Reset: RST pulse mid-ROUND (counter=5) -> all strobes 0 in the same cycle, in_ready=1 after
//     release, busy=0.
//   2 Single block: in_valid for 1 cycle at edge E, out_ready=1 -> ks_load@E+1, dp_add0@E+2,
//     dp_round_en@E+3..E+12, dp_skip_mix only @E+12, out_valid@E+13 for 1 cycle.
//     With the key-expansion unit and FIPS-197 key 2b7e1516.. attached, the round-10 key is
//     d014f9a8c9ee2589e13f0cc8b6630ca6.
//   3 Backpressure: out_ready=0 for 7 cycles in DONE -> out_valid held, round_idx=10, in_ready=0,
//     no strobes. Release -> IDLE next cycle.
//   4 Back-to-back: in_valid held high across two blocks -> second accept exactly 14 cycles after
//     the first. ks_load pulses again, and the strobe counts equal 10 per block.
//   5 Flush: flush in ROUND with counter=4 -> IDLE next cycle. A new request runs the full
//     sequence, starting with ks_load. flush && in_valid in IDLE -> no accept.
//   6 Parameter: NUM_ROUNDS=2 -> dp_round_en@E+3,E+4, skip_mix@E+4, out_valid@E+5, ks_step count=2.

Source files
------------

// File: rtl/aes_round_sched_if.sv
// Handshake and strobe bundle between the AES round sequencer and its surroundings.
// master = the sequencer, slave = requester / consumer / key unit / datapath side.
interface aes_round_sched_if #(
  parameter int RIDX_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              ks_load;
  logic              ks_step;
  logic              dp_load;
  logic              dp_add0;
  logic              dp_round_en;
  logic              dp_skip_mix;
  logic [RIDX_W-1:0] round_idx;
  logic              busy;

  modport master (
    input  flush, in_valid, out_ready,
    output in_ready, out_valid, ks_load, ks_step, dp_load, dp_add0,
           dp_round_en, dp_skip_mix, round_idx, busy
  );

  modport slave (
    output flush, in_valid, out_ready,
    input  in_ready, out_valid, ks_load, ks_step, dp_load, dp_add0,
           dp_round_en, dp_skip_mix, round_idx, busy
  );
endinterface

// File: rtl/aes_round_sched.sv
// Control sequencer for one AES-128 block: key load, initial AddRoundKey, NUM_ROUNDS rounds,
// then holds the result until the consumer takes it. No key or state data passes through here.
module aes_round_sched #(
  parameter int NUM_ROUNDS = 10,
  parameter int RIDX_W     = 4
) (
  input  logic               CLK,
  input  logic               RST,
  aes_round_sched_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD0  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NUM_ROUNDS);

  state_t            state_reg, state_next;
  logic [RIDX_W-1:0] cnt_reg, cnt_next;

  logic              in_ready;
  logic              out_valid;
  logic              ks_load;
  logic              ks_step;
  logic              dp_load;
  logic              dp_add0;
  logic              dp_round_en;
  logic              dp_skip_mix;
  logic [RIDX_W-1:0] round_idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    ks_load     = 1'b0;
    ks_step     = 1'b0;
    dp_load     = 1'b0;
    dp_add0     = 1'b0;
    dp_round_en = 1'b0;
    dp_skip_mix = 1'b0;
    round_idx   = '0;

    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        cnt_next = '0;
        if (bus.in_valid) state_next = S_LOAD;
      end
      S_LOAD: begin
        ks_load    = 1'b1;
        dp_load    = 1'b1;
        cnt_next   = '0;
        state_next = S_ADD0;
      end
      S_ADD0: begin
        dp_add0    = 1'b1;
        ks_step    = 1'b1;
        cnt_next   = RIDX_W'(1);
        state_next = S_ROUND;
      end
      S_ROUND: begin
        round_idx = cnt_reg;
        if (cnt_reg == LAST_ROUND) begin
          dp_round_en = 1'b1;
          dp_skip_mix = 1'b1;
          state_next  = S_DONE;
        end else if (cnt_reg > LAST_ROUND) begin
          // Unreachable counter value: abandon the block rather than run a bogus round.
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          // Step the key unit now so the next round key is ready for the next round.
          dp_round_en = 1'b1;
          ks_step     = 1'b1;
          cnt_next    = cnt_reg + RIDX_W'(1);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        round_idx = LAST_ROUND;
        if (bus.out_ready || (cnt_reg > LAST_ROUND)) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase

    // Abort wins over any accept or completion decided above.
    if (bus.flush) begin
      cnt_next   = '0;
      state_next = S_IDLE;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.ks_load     = ks_load;
  assign bus.ks_step     = ks_step;
  assign bus.dp_load     = dp_load;
  assign bus.dp_add0     = dp_add0;
  assign bus.dp_round_en = dp_round_en;
  assign bus.dp_skip_mix = dp_skip_mix;
  assign bus.round_idx   = round_idx;
  assign bus.busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: a default 10-round instance with an AES-128 key-expansion
// model hung off its ks_load/ks_step, and a 2-round instance for the short-schedule case.
module tb_aes_round_sched;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  aes_round_sched_if #(.RIDX_W(4)) ifa ();
  aes_round_sched_if #(.RIDX_W(4)) ifb ();

  aes_round_sched #(.NUM_ROUNDS(10), .RIDX_W(4)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
  aes_round_sched #(.NUM_ROUNDS(2),  .RIDX_W(4)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

  // {ks_load, ks_step, dp_load, dp_add0, dp_round_en, dp_skip_mix, out_valid, in_ready, busy}
  localparam logic [8:0] V_IDLE  = 9'b000000010;
  localparam logic [8:0] V_LOAD  = 9'b101000001;
  localparam logic [8:0] V_ADD0  = 9'b010100001;
  localparam logic [8:0] V_ROUND = 9'b000010001;
  localparam logic [8:0] V_STEP  = 9'b010000000;
  localparam logic [8:0] V_SKIP  = 9'b000001000;
  localparam logic [8:0] V_DONE  = 9'b000000101;

  localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10       = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int checks   = 0;
  int failures = 0;

  // Strobe counters, sampled on the active edge.
  int a_load = 0, a_step = 0, a_ren = 0, a_skip = 0;
  int b_step = 0, b_ren = 0;
  always @(posedge CLK) begin
    if (ifa.ks_load)     a_load++;
    if (ifa.ks_step)     a_step++;
    if (ifa.dp_round_en) a_ren++;
    if (ifa.dp_skip_mix) a_skip++;
    if (ifb.ks_step)     b_step++;
    if (ifb.dp_round_en) b_ren++;
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {w3[23:0], w3[31:24]};
    t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Key-expansion unit model driven by dut_a's key strobes.
  logic [127:0] rk   = '0;
  logic [7:0]   rcon = 8'h01;
  always @(posedge CLK) begin
    if (ifa.ks_load) begin
      rk   <= CIPHER_KEY;
      rcon <= 8'h01;
    end else if (ifa.ks_step) begin
      rk   <= key_next(rk, rcon);
      rcon <= rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obs_vec(input int sel);
    if (sel == 0)
      return {ifa.ks_load, ifa.ks_step, ifa.dp_load, ifa.dp_add0, ifa.dp_round_en,
              ifa.dp_skip_mix, ifa.out_valid, ifa.in_ready, ifa.busy};
    return {ifb.ks_load, ifb.ks_step, ifb.dp_load, ifb.dp_add0, ifb.dp_round_en,
            ifb.dp_skip_mix, ifb.out_valid, ifb.in_ready, ifb.busy};
  endfunction

  task automatic expect_state(input int sel, input string tag, input logic [8:0] vec,
                              input int idx);
    chk({tag, "_sig"}, 128'(obs_vec(sel)), 128'(vec));
    chk({tag, "_idx"}, 128'((sel == 0) ? ifa.round_idx : ifb.round_idx), 128'(idx));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full block on the selected instance; DONE is held for hold_cycles extra cycles.
  task automatic run_block(input int sel, input int nr, input int hold_cycles, input string name);
    if (sel == 0) begin ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; end
    else          begin ifb.out_ready = 1'b0; ifb.in_valid = 1'b1; end
    tick();
    if (sel == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
    expect_state(sel, {name, "_load"}, V_LOAD, 0);
    tick();
    expect_state(sel, {name, "_add0"}, V_ADD0, 0);
    for (int r = 1; r <= nr; r++) begin
      tick();
      expect_state(sel, $sformatf("%s_round%0d", name, r),
                   V_ROUND | ((r < nr) ? V_STEP : 9'd0) | ((r == nr) ? V_SKIP : 9'd0), r);
    end
    tick();
    expect_state(sel, {name, "_done"}, V_DONE, nr);
    if (sel == 0) chk({name, "_rk10"}, rk, RK10);
    for (int h = 0; h < hold_cycles; h++) begin
      tick();
      expect_state(sel, $sformatf("%s_hold%0d", name, h), V_DONE, nr);
    end
    if (sel == 0) ifa.out_ready = 1'b1; else ifb.out_ready = 1'b1;
    tick();
    expect_state(sel, {name, "_idle"}, V_IDLE, 0);
    $display("block %s dut=%0d rounds=%0d hold=%0d complete", name, sel, nr, hold_cycles);
  endtask

  initial begin
    int snap_load, snap_step, snap_ren, snap_skip, snap_bs, snap_br, gap;
    bit seen;
    ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;

    // Reset state, during and after reset
    #1;
    expect_state(0, "rst_hold_a", V_IDLE, 0);
    expect_state(1, "rst_hold_b", V_IDLE, 0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    expect_state(0, "rst_exit", V_IDLE, 0);

    // Single block, consumer ready
    snap_load = a_load; snap_step = a_step; snap_ren = a_ren; snap_skip = a_skip;
    run_block(0, 10, 0, "single");
    chk("single_ks_load_cnt", 128'(a_load - snap_load), 128'd1);
    chk("single_ks_step_cnt", 128'(a_step - snap_step), 128'd10);
    chk("single_round_cnt",   128'(a_ren - snap_ren),   128'd10);
    chk("single_skip_cnt",    128'(a_skip - snap_skip), 128'd1);

    // Backpressure: DONE held for 7 extra cycles
    run_block(0, 10, 7, "bp");

    // Asynchronous reset in ROUND with counter 5
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    expect_state(0, "pre_rst_round5", V_ROUND | V_STEP, 5);
    RST = 1'b1;
    #1;
    expect_state(0, "rst_mid_round", V_IDLE, 0);
    tick();
    RST = 1'b0;
    #1;
    expect_state(0, "rst_mid_release", V_IDLE, 0);
    tick();
    expect_state(0, "rst_mid_after", V_IDLE, 0);
    $display("block reset_mid_round dut=0 aborted at round 5");

    // Back-to-back with in_valid held high
    snap_load = a_load; snap_step = a_step; snap_ren = a_ren; snap_skip = a_skip;
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    tick();
    gap = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      gap++;
      if (ifa.ks_load) seen = 1'b1;
    end
    chk("b2b_second_accept_seen", 128'(seen), 128'd1);
    chk("b2b_accept_gap", 128'(gap), 128'd14);
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    expect_state(0, "b2b_idle", V_IDLE, 0);
    chk("b2b_ks_load_cnt", 128'(a_load - snap_load), 128'd2);
    chk("b2b_ks_step_cnt", 128'(a_step - snap_step), 128'd20);
    chk("b2b_round_cnt",   128'(a_ren - snap_ren),   128'd20);
    chk("b2b_skip_cnt",    128'(a_skip - snap_skip), 128'd2);
    $display("block back_to_back dut=0 gap=%0d", gap);

    // Flush in ROUND with counter 4, then a fresh block
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    expect_state(0, "pre_flush_round4", V_ROUND | V_STEP, 4);
    ifa.flush = 1'b1;
    tick();
    ifa.flush = 1'b0;
    expect_state(0, "flush_idle", V_IDLE, 0);
    $display("block flush dut=0 aborted at round 4");
    run_block(0, 10, 0, "post_flush");

    // flush together with in_valid in IDLE: no accept
    ifa.flush = 1'b1;
    ifa.in_valid = 1'b1;
    tick();
    expect_state(0, "flush_vs_valid", V_IDLE, 0);
    ifa.flush = 1'b0;
    ifa.in_valid = 1'b0;
    tick();
    expect_state(0, "flush_vs_valid_after", V_IDLE, 0);

    // Two-round instance
    snap_bs = b_step; snap_br = b_ren;
    run_block(1, 2, 0, "nr2");
    chk("nr2_ks_step_cnt", 128'(b_step - snap_bs), 128'd2);
    chk("nr2_round_cnt",   128'(b_ren - snap_br),  128'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
